// File: rtl/bill_arbiter_if.sv
// -----------------------------------------------------------------------------
// bill_arbiter_if
//   Booth-side bus of the shared billing engine.
//
//   Handshake: a booth raises req[i] (with cat[2i+1:2i]) and holds it until it
//   sees ack[i]. ack is a one-cycle, one-hot pulse and ok is valid only in
//   that cycle. The booth must drop req[i] on ack, otherwise the next idle
//   cycle treats it as a fresh request.
//
//   Signals (master = booth/keypad side, slave = bill_arbiter):
//     req       [N_LINES]    per-line deduct request (level)
//     cat       [2*N_LINES]  per-line call category
//     add_en                 one-cycle recharge strobe
//     add_line  [LW]         recharge target line
//     add_amt   [BAL_W]      recharge amount in jiao
//     bal_sel   [LW]         line shown on bal_out
//     ack       [N_LINES]    one-hot completion pulse
//     ok                     1 = debited or free, 0 = insufficient balance
//     busy                   arbiter not idle
//     add_ovf                recharge strobe dropped this cycle
//     bal_out   [BAL_W]      registered balance of bal_sel
//     dbg_state [2]          current FSM state, for observation only
// -----------------------------------------------------------------------------
interface bill_arbiter_if #(
    parameter int N_LINES = 4,
    parameter int LW      = 2,
    parameter int BAL_W   = 10
);
    logic [N_LINES-1:0]   req;
    logic [2*N_LINES-1:0] cat;
    logic                 add_en;
    logic [LW-1:0]        add_line;
    logic [BAL_W-1:0]     add_amt;
    logic [LW-1:0]        bal_sel;
    logic [N_LINES-1:0]   ack;
    logic                 ok;
    logic                 busy;
    logic                 add_ovf;
    logic [BAL_W-1:0]     bal_out;
    logic [1:0]           dbg_state;

    modport master (
        output req, cat, add_en, add_line, add_amt, bal_sel,
        input  ack, ok, busy, add_ovf, bal_out, dbg_state
    );

    modport slave (
        input  req, cat, add_en, add_line, add_amt, bal_sel,
        output ack, ok, busy, add_ovf, bal_out, dbg_state
    );
endinterface

// File: rtl/bill_arbiter.sv
// -----------------------------------------------------------------------------
// bill_arbiter
//   Shared per-minute billing engine for a multi-booth payphone. Round-robin
//   arbitration among booth deduct requests, a private balance store per
//   line, and a one-entry buffer that sequences keypad recharges into idle
//   cycles.
//
//   Ports:
//     clk  system clock, rising edge
//     clr  asynchronous active-high reset
//     bus  bill_arbiter_if.slave (requests, recharges, ack/ok, readout)
//
//   Transaction: IDLE (accept) -> GRANT (cost) -> CHECK (compare) ->
//   WRITE (debit + ack). ack appears three cycles after acceptance.
// -----------------------------------------------------------------------------
module bill_arbiter #(
    parameter int N_LINES    = 4,
    parameter int LW         = 2,
    parameter int BAL_W      = 10,
    parameter int BAL_MAX    = 999,
    parameter int COST_LOCAL = 3,
    parameter int COST_LONG  = 6
) (
    input logic          clk,
    input logic          clr,
    bill_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam logic [BAL_W-1:0] BAL_MAX_V    = BAL_W'(BAL_MAX);
    localparam logic [BAL_W:0]   BAL_MAX_W    = (BAL_W+1)'(BAL_MAX);
    localparam logic [BAL_W-1:0] COST_LOCAL_V = BAL_W'(COST_LOCAL);
    localparam logic [BAL_W-1:0] COST_LONG_V  = BAL_W'(COST_LONG);

    logic [1:0]       state_q, state_d;
    logic [LW-1:0]    ptr_q, ptr_d;
    logic [LW-1:0]    g_q, g_d;
    logic [BAL_W-1:0] cost_q, cost_d;
    logic             suff_q, suff_d;
    logic [BAL_W-1:0] bal_q [N_LINES];
    logic [BAL_W-1:0] bal_d [N_LINES];
    logic             pend_v_q, pend_v_d;
    logic [LW-1:0]    pend_line_q, pend_line_d;
    logic [BAL_W-1:0] pend_amt_q, pend_amt_d;
    logic [BAL_W-1:0] bal_out_q, bal_out_d;

    logic             pick_found;
    logic [LW-1:0]    pick_idx;
    logic [LW-1:0]    cand;
    logic             drain;
    logic             drop;
    logic [BAL_W:0]   sat_sum;
    logic [1:0]       cat_g;

    // Round-robin: first requesting line at or after the pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < N_LINES; k++) begin
            cand = LW'((int'(ptr_q) + k) % N_LINES);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign cat_g   = bus.cat[{g_q, 1'b0} +: 2];
    assign drain   = (state_q == S_IDLE) && pend_v_q;
    // A strobe is dropped only when the buffer is full and not emptying now.
    assign drop    = bus.add_en && pend_v_q && !drain;
    assign sat_sum = {1'b0, bal_q[pend_line_q]} + {1'b0, pend_amt_q};

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        g_d         = g_q;
        cost_d      = cost_q;
        suff_d      = suff_q;
        bal_d       = bal_q;
        pend_v_d    = pend_v_q;
        pend_line_d = pend_line_q;
        pend_amt_d  = pend_amt_q;

        case (state_q)
            S_IDLE: begin
                // A pending recharge wins over requests for this cycle.
                if (pend_v_q) begin
                    bal_d[pend_line_q] = (sat_sum > BAL_MAX_W) ? BAL_MAX_V
                                                               : sat_sum[BAL_W-1:0];
                end else if (pick_found) begin
                    g_d     = pick_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                case (cat_g)
                    2'b01:   cost_d = COST_LOCAL_V;
                    2'b10:   cost_d = COST_LONG_V;
                    default: cost_d = '0;
                endcase
                state_d = S_CHECK;
            end
            S_CHECK: begin
                suff_d  = (bal_q[g_q] >= cost_q);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (suff_q) begin
                    bal_d[g_q] = bal_q[g_q] - cost_q;
                end
                ptr_d   = (g_q == LW'(N_LINES - 1)) ? '0 : g_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Recharge buffer: a strobe landing in a drain cycle refills it.
        if (bus.add_en && (!pend_v_q || drain)) begin
            pend_v_d    = 1'b1;
            pend_line_d = bus.add_line;
            pend_amt_d  = bus.add_amt;
        end else if (drain) begin
            pend_v_d = 1'b0;
        end

        // Readout reflects updates made in the same cycle.
        bal_out_d = bal_d[bus.bal_sel];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            g_q         <= '0;
            cost_q      <= '0;
            suff_q      <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_line_q <= '0;
            pend_amt_q  <= '0;
            bal_out_q   <= '0;
            for (int i = 0; i < N_LINES; i++) begin
                bal_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            g_q         <= g_d;
            cost_q      <= cost_d;
            suff_q      <= suff_d;
            pend_v_q    <= pend_v_d;
            pend_line_q <= pend_line_d;
            pend_amt_q  <= pend_amt_d;
            bal_out_q   <= bal_out_d;
            for (int i = 0; i < N_LINES; i++) begin
                bal_q[i] <= bal_d[i];
            end
        end
    end

    assign bus.ack       = (state_q == S_WRITE) ? (N_LINES'(1) << g_q) : '0;
    assign bus.ok        = (state_q == S_WRITE) && suff_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.add_ovf   = drop;
    assign bus.bal_out   = bal_out_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bill_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bill_arbiter
//   Directed and randomized bench for bill_arbiter. A transaction-level model
//   keeps per-line balances and the round-robin pointer; every ack, ok and
//   balance readout is compared against it.
// -----------------------------------------------------------------------------
module tb_bill_arbiter;
    localparam int N       = 4;
    localparam int BAL_MAX = 999;

    logic clk = 1'b0;
    logic clr = 1'b1;

    bill_arbiter_if #(.N_LINES(4), .LW(2), .BAL_W(10)) bus();

    bill_arbiter #(
        .N_LINES(4), .LW(2), .BAL_W(10), .BAL_MAX(999),
        .COST_LOCAL(3), .COST_LONG(6)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_bal [N];
    int m_ptr;
    logic [31:0] exp_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cost_of(input logic [1:0] c);
        if (c == 2'b01) return 3;
        if (c == 2'b10) return 6;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_bal[i] = 0;
        m_ptr = 0;
    endtask

    // Recharge issued in an idle cycle; applied in the following idle cycle.
    task automatic recharge(input int line, input int amt);
        bus.add_en   = 1'b1;
        bus.add_line = line[1:0];
        bus.add_amt  = amt[9:0];
        step();
        bus.add_en = 1'b0;
        step();
        m_bal[line] = (m_bal[line] + amt > BAL_MAX) ? BAL_MAX : m_bal[line] + amt;
    endtask

    task automatic check_bal(input int line, input string tag);
        bus.bal_sel = line[1:0];
        step();
        chk(tag, bus.bal_out, m_bal[line]);
    endtask

    task automatic check_all_bal(input string tag);
        for (int l = 0; l < N; l++) exp_q.push_back(m_bal[l]);
        for (int l = 0; l < N; l++) begin
            bus.bal_sel = l[1:0];
            step();
            chk(tag, bus.bal_out, exp_q.pop_front());
        end
    endtask

    // Raise mask, collect n_acks acks; drop each req on its ack when drop=1.
    task automatic service(input logic [3:0] mask, input logic [7:0] cats,
                           input int n_acks, input bit drop, input string tag);
        logic [3:0] pend;
        int k;
        int exp_line;
        int c;
        bit exp_ok;
        pend    = mask;
        bus.cat = cats;
        bus.req = mask;
        for (int a = 0; a < n_acks; a++) begin
            k = 0;
            do begin
                step();
                k++;
            end while (bus.ack === 4'b0000 && k < 12);
            chk({tag, "_lat"}, k, (a == 0) ? 3 : 4);
            exp_line = 0;
            for (int j = N - 1; j >= 0; j--) begin
                if (pend[(m_ptr + j) % N]) exp_line = (m_ptr + j) % N;
            end
            c      = cost_of(cats[2*exp_line +: 2]);
            exp_ok = (c == 0) || (m_bal[exp_line] >= c);
            chk({tag, "_ack"}, bus.ack, 32'(1) << exp_line);
            chk({tag, "_ok"}, bus.ok, exp_ok);
            if (exp_ok) m_bal[exp_line] -= c;
            m_ptr = (exp_line + 1) % N;
            if (drop) begin
                pend[exp_line] = 1'b0;
                bus.req = pend;
            end
        end
        bus.req = 4'b0000;
        step();
    endtask

    initial begin
        logic [3:0] mask;
        logic [7:0] cats;
        int c;

        bus.req = '0; bus.cat = '0; bus.add_en = 1'b0;
        bus.add_line = '0; bus.add_amt = '0; bus.bal_sel = '0;
        model_reset();

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_ack", bus.ack, 0);
        chk("rst_ok", bus.ok, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ovf", bus.add_ovf, 0);
        chk("rst_bal", bus.bal_out, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        step();

        // Recharge then a local call on line 1
        recharge(1, 50);
        service(4'b0010, 8'b0000_0100, 1, 1'b1, "t1");
        check_bal(1, "t1_bal");

        // Insufficient long-distance, then sufficient local on line 2
        recharge(2, 5);
        service(4'b0100, 8'b0010_0000, 1, 1'b1, "t2a");
        check_bal(2, "t2a_bal");
        service(4'b0100, 8'b0001_0000, 1, 1'b1, "t2b");
        check_bal(2, "t2b_bal");

        // Free category on an empty line
        service(4'b1000, 8'b1100_0000, 1, 1'b1, "t6");
        check_bal(3, "t6_bal");

        // Saturation
        recharge(0, 990);
        recharge(0, 50);
        check_bal(0, "t4_sat");

        // Recharge of the in-flight line while busy; second strobe dropped
        bus.cat = 8'b0001_0000;
        bus.req = 4'b0100;
        step();
        chk("t4_busy", bus.busy, 1);
        bus.add_en = 1'b1; bus.add_line = 2'd2; bus.add_amt = 10'd7;
        #1;
        chk("t4_ovf0", bus.add_ovf, 0);
        step();
        bus.add_amt = 10'd9;
        #1;
        chk("t4_ovf1", bus.add_ovf, 1);
        step();
        bus.add_en = 1'b0;
        #1;
        chk("t4_ovf2", bus.add_ovf, 0);
        c = cost_of(2'b01);
        chk("t4_ack", bus.ack, 32'(1) << 2);
        chk("t4_ok", bus.ok, (m_bal[2] >= c) ? 1 : 0);
        if (m_bal[2] >= c) m_bal[2] -= c;
        m_ptr = 3;
        bus.req = 4'b0000;
        step();
        m_bal[2] = (m_bal[2] + 7 > BAL_MAX) ? BAL_MAX : m_bal[2] + 7;
        check_bal(2, "t4_drain");

        // Reset while in CHECK
        bus.cat = 8'b0000_0001;
        bus.req = 4'b0001;
        step();
        step();
        chk("t5_busy_pre", bus.busy, 1);
        clr = 1'b1;
        #1;
        chk("t5_busy", bus.busy, 0);
        chk("t5_ack", bus.ack, 0);
        chk("t5_bal_out", bus.bal_out, 0);
        bus.req = 4'b0000;
        model_reset();
        #1;
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_noack", bus.ack, 0);
        end
        check_all_bal("t5_bal");

        // All lines requesting continuously
        for (int l = 0; l < N; l++) recharge(l, 100);
        service(4'b1111, 8'b0101_0101, 5, 1'b0, "t3");
        check_all_bal("t3_bal");

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                recharge(int'($urandom_range(0, 3)), int'($urandom_range(0, 400)));
            end else begin
                mask = 4'($urandom_range(1, 15));
                cats = 8'($urandom);
                service(mask, cats, $countones(mask), 1'b1, "rnd");
            end
        end
        check_all_bal("rnd_bal");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
